node_dispatch: RTL

NODE_DISPATCH -- requirements
Module: node_dispatch

---
 rtl/node_dispatch.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/node_dispatch.sv
// node_dispatch
//
// Takes one task at a time from upstream and hands it to a free child channel.
// Free children are chosen in round-robin order after the last child served.
// Each child stays busy until it pulses child_done. The block also keeps
// wrapping counters of issued and completed tasks. It raises a sticky error
// flag when a child reports done while it is not busy.
//
// Ports
//   clk, rst_n     : clock (rising edge) and asynchronous active-low reset
//   in_valid/ready : upstream handshake; in_data is latched on acceptance
//   child_valid    : one-hot offer to the selected child (ISSUE state only)
//   child_data     : latched payload, shared by all children
//   child_ready    : per-child accept; only the selected bit is honoured
//   child_done     : per-child completion pulse
//   busy           : registered per-child occupancy
//   idle           : nothing held and no child busy
//   issued_cnt     : tasks handed to children (wraps)
//   done_cnt       : completions accepted (wraps)
//   err            : sticky flag for a done pulse from a non-busy child
module node_dispatch #(
  parameter int NUM_CHILD = 5,
  parameter int DATA_W    = 16,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  output logic [NUM_CHILD-1:0] child_valid,
  output logic [DATA_W-1:0]    child_data,
  input  logic [NUM_CHILD-1:0] child_ready,
  input  logic [NUM_CHILD-1:0] child_done,
  output logic [NUM_CHILD-1:0] busy,
  output logic                 idle,
  output logic [CNT_W-1:0]     issued_cnt,
  output logic [CNT_W-1:0]     done_cnt,
  output logic                 err
);

  localparam int PTR_W = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1;

  typedef enum logic [1:0] {EMPTY, HOLD, ISSUE} state_t;

  state_t               state, state_next;
  logic                 live;
  logic [PTR_W-1:0]     ptr, sel, pick;
  logic [PTR_W:0]       cand;
  logic                 pick_found;
  logic [DATA_W-1:0]    data_q;
  logic [NUM_CHILD-1:0] busy_q, done_ok, done_bad, issue_bit;
  logic                 accept, handshake;
  logic [CNT_W-1:0]     done_add;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  // Next state and handshake outputs. in_ready is also gated by 'live'.
  // This keeps it low while reset is asserted and lets it rise only on the
  // first edge after release.
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    handshake   = 1'b0;
    in_ready    = 1'b0;
    child_valid = '0;
    case (state)
      EMPTY: begin
        in_ready = live;
        if (live && in_valid) begin
          accept     = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (pick_found) state_next = ISSUE;
      end
      ISSUE: begin
        child_valid = NUM_CHILD'(1) << sel;
        if (|(child_valid & child_ready)) begin
          handshake  = 1'b1;
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // Round-robin search from ptr+1 over the registered busy vector. A done
  // arriving this cycle is therefore not seen until the next cycle. The
  // candidate is one bit wider so that the modulo wrap never overflows.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    cand       = '0;
    for (int k = 1; k <= NUM_CHILD; k++) begin
      cand = {1'b0, ptr} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_CHILD)) cand = cand - (PTR_W+1)'(NUM_CHILD);
      if (!pick_found && !busy_q[cand[PTR_W-1:0]]) begin
        pick       = cand[PTR_W-1:0];
        pick_found = 1'b1;
      end
    end
  end

  // Completion classification and the number of valid dones in this cycle
  always_comb begin
    done_ok   = child_done & busy_q;
    done_bad  = child_done & ~busy_q;
    issue_bit = handshake ? child_valid : '0;
    done_add  = '0;
    for (int i = 0; i < NUM_CHILD; i++) done_add = done_add + CNT_W'(done_ok[i]);
  end

  // Datapath, occupancy and statistics. A done from one child and an issue
  // to a different child in the same cycle both land in busy_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live       <= 1'b0;
      ptr        <= PTR_W'(NUM_CHILD - 1);
      sel        <= '0;
      data_q     <= '0;
      busy_q     <= '0;
      issued_cnt <= '0;
      done_cnt   <= '0;
      err        <= 1'b0;
    end else begin
      live <= 1'b1;
      if (accept) data_q <= in_data;
      if (state == HOLD && pick_found) sel <= pick;
      busy_q <= (busy_q & ~done_ok) | issue_bit;
      if (handshake) begin
        ptr        <= sel;
        issued_cnt <= issued_cnt + CNT_W'(1);
      end
      done_cnt <= done_cnt + done_add;
      if (|done_bad) err <= 1'b1;
    end
  end

  assign busy       = busy_q;
  assign child_data = data_q;
  assign idle       = live && (state == EMPTY) && (busy_q == '0);

endmodule
